// File: rtl/wsacc_cluster_sequencer_if.sv
// ----------------------------------------------------------------------------
// wsacc_cluster_sequencer_if
// Bundles the bus signals of the wsacc cluster tile sequencer: the weight SRAM
// read port, the cluster weight load port, the window source handshake and the
// cluster data handshake (including the snooped output-fire strobe).
//
// Signals (direction seen from the sequencer, modport master):
//   wmem_re            out  weight SRAM read enable
//   wmem_addr          out  weight SRAM read address
//   wmem_rdata         in   weight SRAM read data, valid 1 cycle after wmem_re
//   weight_itf_o       out  weight word to cluster weight_itf_i
//   weight_itf_valid_o out  to cluster weight_itf_i_valid
//   src_valid_i        in   window source valid
//   src_ready_o        out  window source ready
//   clu_valid_o        out  to cluster data_i_valid
//   clu_ready_i        in   from cluster data_i_ready
//   clu_out_fire_i     in   cluster data_o_valid && data_o_ready
// The slave modport is the environment side (SRAM, source, cluster).
// ----------------------------------------------------------------------------
interface wsacc_cluster_sequencer_if #(
    parameter int unsigned weightInterfaceWidth = 32,
    parameter int unsigned wAddrWidth           = 12
);
    logic                            wmem_re;
    logic [wAddrWidth-1:0]           wmem_addr;
    logic [weightInterfaceWidth-1:0] wmem_rdata;
    logic [weightInterfaceWidth-1:0] weight_itf_o;
    logic                            weight_itf_valid_o;
    logic                            src_valid_i;
    logic                            src_ready_o;
    logic                            clu_valid_o;
    logic                            clu_ready_i;
    logic                            clu_out_fire_i;

    modport master (
        output wmem_re,
        output wmem_addr,
        input  wmem_rdata,
        output weight_itf_o,
        output weight_itf_valid_o,
        input  src_valid_i,
        output src_ready_o,
        output clu_valid_o,
        input  clu_ready_i,
        input  clu_out_fire_i
    );

    modport slave (
        input  wmem_re,
        input  wmem_addr,
        output wmem_rdata,
        input  weight_itf_o,
        input  weight_itf_valid_o,
        output src_valid_i,
        input  src_ready_o,
        input  clu_valid_o,
        output clu_ready_i,
        output clu_out_fire_i
    );
endinterface

// File: rtl/wsacc_cluster_sequencer.sv
// ----------------------------------------------------------------------------
// wsacc_cluster_sequencer
// Tile-level controller for one wsacc PE cluster. For each of cfg_num_tiles
// contiguous weight tiles it streams the tile's weight words from the weight
// SRAM into the cluster weight port, then admits exactly cfg_windows input
// windows and waits until all of their outputs have drained from the cluster.
//
// Ports:
//   clk              in   clock
//   nrst             in   asynchronous reset, active-low
//   i_start          in   pulse; starts a job when idle (ignored while busy)
//   i_cfg_num_tiles  in   tiles in the job (0 = immediate done)
//   i_cfg_windows    in   windows per tile
//   i_cfg_wbase      in   first weight word address
//   o_busy           out  job in progress
//   o_done           out  1-cycle pulse at job end
//   o_tile_idx       out  current tile index
//   o_perf_stall     out  source-stall cycle counter (0 unless built in)
//   bus              --   wsacc_cluster_sequencer_if.master (SRAM, weights,
//                         window source and cluster handshakes)
//
// Build option:
//   WSACC_SEQ_PERF_EN  when defined, o_perf_stall counts STREAM cycles where a
//                      window is offered and allowed but the cluster is not
//                      ready; cleared on start, saturating, held after done.
//                      When undefined, o_perf_stall is tied to 0.
// ----------------------------------------------------------------------------
module wsacc_cluster_sequencer #(
    parameter int unsigned numPes               = 32,
    parameter int unsigned windowElements       = 9,
    parameter int unsigned weightInterfaceWidth = 32,
    parameter int unsigned wAddrWidth           = 12
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_start,
    input  logic [7:0]            i_cfg_num_tiles,
    input  logic [15:0]           i_cfg_windows,
    input  logic [wAddrWidth-1:0] i_cfg_wbase,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [7:0]            o_tile_idx,
    output logic [31:0]           o_perf_stall,
    wsacc_cluster_sequencer_if.master bus
);

    localparam int unsigned dataWidth    = 8;
    localparam int unsigned pesPerWord   = weightInterfaceWidth / dataWidth;
    localparam int unsigned numWriteSets = (numPes + pesPerWord - 1) / pesPerWord;
    localparam int unsigned wordsPerTile = numWriteSets * windowElements;
    localparam int unsigned rdCntWidth   = $clog2(wordsPerTile + 1);

    localparam logic [rdCntWidth-1:0] lastRead = rdCntWidth'(wordsPerTile - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLflush,
        StStream,
        StDrain
    } state_e;

    state_e                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [7:0]            r_tile_idx;
    logic [7:0]            r_num_tiles;
    logic [15:0]           r_windows;
    logic                  r_wmem_re;
    logic [wAddrWidth-1:0] r_wmem_addr;
    logic                  r_wvalid;
    logic [rdCntWidth-1:0] r_rd_cnt;
    logic [15:0]           r_in_cnt;
    logic [15:0]           r_out_cnt;

    logic                  w_gate_open;
    logic                  w_src_ready;
    logic                  w_in_fire;
    logic [15:0]           w_in_next;
    logic                  w_out_fire;
    logic                  w_last_tile;

    // Windows are admitted only in STREAM and only until the per-tile quota is met.
    assign w_gate_open = (r_state == StStream) && (r_in_cnt < r_windows);
    assign w_src_ready = bus.clu_ready_i & w_gate_open;
    assign w_in_fire   = bus.src_valid_i & w_src_ready;
    assign w_in_next   = r_in_cnt + {15'd0, w_in_fire};

    // Output fires are only meaningful once windows can be in flight.
    assign w_out_fire  = bus.clu_out_fire_i &&
                         ((r_state == StStream) || (r_state == StDrain));

    // 9-bit compare so tile_idx + 1 never wraps.
    assign w_last_tile = ({1'b0, r_tile_idx} + 9'd1) >= {1'b0, r_num_tiles};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tile_idx  <= '0;
            r_num_tiles <= '0;
            r_windows   <= '0;
            r_wmem_re   <= 1'b0;
            r_wmem_addr <= '0;
            r_wvalid    <= 1'b0;
            r_rd_cnt    <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
        end else begin
            r_done   <= 1'b0;
            // SRAM data arrives one cycle after the read, so valid follows re.
            r_wvalid <= r_wmem_re;

            if (w_out_fire && (r_out_cnt != 16'hFFFF)) begin
                r_out_cnt <= r_out_cnt + 16'd1;
            end

            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_num_tiles <= i_cfg_num_tiles;
                        r_windows   <= i_cfg_windows;
                        if (i_cfg_num_tiles == 8'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy      <= 1'b1;
                            r_tile_idx  <= '0;
                            r_wmem_re   <= 1'b1;
                            r_wmem_addr <= i_cfg_wbase;
                            r_rd_cnt    <= '0;
                            r_in_cnt    <= '0;
                            r_out_cnt   <= '0;
                            r_state     <= StLoad;
                        end
                    end
                end

                StLoad: begin
                    // Address keeps running after the burst so the next tile
                    // continues where this one stopped.
                    r_wmem_addr <= r_wmem_addr + wAddrWidth'(1);
                    r_rd_cnt    <= r_rd_cnt + rdCntWidth'(1);
                    if (r_rd_cnt == lastRead) begin
                        r_wmem_re <= 1'b0;
                        r_state   <= StLflush;
                    end
                end

                StLflush: begin
                    r_state <= StStream;
                end

                StStream: begin
                    r_in_cnt <= w_in_next;
                    if (w_in_next == r_windows) begin
                        r_state <= StDrain;
                    end
                end

                StDrain: begin
                    if (r_out_cnt >= r_windows) begin
                        if (!w_last_tile) begin
                            r_tile_idx <= r_tile_idx + 8'd1;
                            r_in_cnt   <= '0;
                            r_out_cnt  <= '0;
                            r_wmem_re  <= 1'b1;
                            r_rd_cnt   <= '0;
                            r_state    <= StLoad;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= StIdle;
                        end
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

`ifdef WSACC_SEQ_PERF_EN
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_perf_stall <= '0;
        end else if ((r_state == StIdle) && i_start) begin
            r_perf_stall <= '0;
        end else if (w_gate_open && bus.src_valid_i && !bus.clu_ready_i &&
                     (r_perf_stall != 32'hFFFF_FFFF)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign o_perf_stall = r_perf_stall;
`else
    assign o_perf_stall = 32'd0;
`endif

    assign o_busy                 = r_busy;
    assign o_done                 = r_done;
    assign o_tile_idx             = r_tile_idx;
    assign bus.wmem_re            = r_wmem_re;
    assign bus.wmem_addr          = r_wmem_addr;
    assign bus.weight_itf_o       = bus.wmem_rdata;
    assign bus.weight_itf_valid_o = r_wvalid;
    assign bus.src_ready_o        = w_src_ready;
    assign bus.clu_valid_o        = bus.src_valid_i & w_gate_open;

endmodule

// File: tb/tb_wsacc_cluster_sequencer.sv
// ----------------------------------------------------------------------------
// tb_wsacc_cluster_sequencer
// Directed bench for wsacc_cluster_sequencer at default parameters. A negedge
// monitor models the weight SRAM checks, window accepts and a simple cluster
// that returns one output per accepted window; directed jobs then compare the
// monitor's tallies with hand-computed values.
// ----------------------------------------------------------------------------
module tb_wsacc_cluster_sequencer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [7:0]  cfg_tiles;
    logic [15:0] cfg_win;
    logic [11:0] cfg_wbase;
    logic        busy;
    logic        done;
    logic [7:0]  tile_idx;
    logic [31:0] perf;

    always #5 clk = ~clk;

    wsacc_cluster_sequencer_if #(.weightInterfaceWidth(32), .wAddrWidth(12)) bus ();

    wsacc_cluster_sequencer #(
        .numPes              (32),
        .windowElements      (9),
        .weightInterfaceWidth(32),
        .wAddrWidth          (12)
    ) u_dut (
        .clk            (clk),
        .nrst           (nrst),
        .i_start        (start),
        .i_cfg_num_tiles(cfg_tiles),
        .i_cfg_windows  (cfg_win),
        .i_cfg_wbase    (cfg_wbase),
        .o_busy         (busy),
        .o_done         (done),
        .o_tile_idx     (tile_idx),
        .o_perf_stall   (perf),
        .bus            (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [11:0] a);
        return 32'hC0DE_0000 | {20'd0, a};
    endfunction

    // Weight SRAM: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.wmem_re) bus.wmem_rdata <= pat(bus.wmem_addr);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state (written only by the monitor process).
    int          clr_req = 0;
    int          clr_ack = 0;
    int          re_cnt = 0, valid_cnt = 0, addr_err = 0, valid_err = 0, data_err = 0;
    int          accepts = 0, done_cnt = 0, viol = 0, real_fires = 0, fires_at_done = 0;
    int          n_bursts = 0, start_cyc = -1, first_acc_cyc = -1, busy_seen = 0, pending = 0;
    logic        got_first = 1'b0;
    logic [11:0] first_addr = '0, last_addr = '0, exp_addr = '0, prev_addr = '0;
    logic        prev_re = 1'b0;
    logic [7:0]  tile_seen [8];
    logic        spurious_en = 1'b0;

    always @(negedge clk) begin
        if (clr_req != clr_ack) begin
            re_cnt = 0; valid_cnt = 0; addr_err = 0; valid_err = 0; data_err = 0;
            accepts = 0; done_cnt = 0; viol = 0; real_fires = 0; fires_at_done = 0;
            n_bursts = 0; start_cyc = -1; first_acc_cyc = -1; busy_seen = 0; pending = 0;
            got_first = 1'b0;
            for (int i = 0; i < 8; i++) tile_seen[i] = 8'hEE;
            clr_ack = clr_req;
        end else begin
            if (bus.wmem_re === 1'b1) begin
                re_cnt++;
                last_addr = bus.wmem_addr;
                if (!got_first) begin
                    got_first  = 1'b1;
                    first_addr = bus.wmem_addr;
                end else if (bus.wmem_addr !== exp_addr) begin
                    addr_err++;
                end
                exp_addr = bus.wmem_addr + 12'd1;
                if (prev_re !== 1'b1) begin
                    if (n_bursts < 8) tile_seen[n_bursts] = tile_idx;
                    n_bursts++;
                end
            end
            if (bus.weight_itf_valid_o === 1'b1) begin
                valid_cnt++;
                if (bus.weight_itf_o !== pat(prev_addr)) data_err++;
            end
            if (bus.weight_itf_valid_o !== prev_re) valid_err++;
            if ((bus.wmem_re === 1'b1 || bus.weight_itf_valid_o === 1'b1) &&
                (bus.clu_valid_o === 1'b1 || bus.src_ready_o === 1'b1)) viol++;
            if (bus.src_valid_i === 1'b1 && bus.src_ready_o === 1'b1) begin
                accepts++;
                pending++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            if (start === 1'b1 && busy === 1'b0 && start_cyc < 0) start_cyc = cyc;
            if (done === 1'b1) begin
                done_cnt++;
                fires_at_done = real_fires;
            end
            if (busy === 1'b1) busy_seen = 1;
        end
        prev_re   = bus.wmem_re;
        prev_addr = bus.wmem_addr;
        // Cluster model: one output per accepted window, spaced by a cycle;
        // optional bogus fires during weight load must be ignored by the DUT.
        if (spurious_en && bus.wmem_re === 1'b1) begin
            bus.clu_out_fire_i = 1'b1;
        end else if (pending > 0 && bus.clu_out_fire_i !== 1'b1) begin
            bus.clu_out_fire_i = 1'b1;
            pending--;
            real_fires++;
        end else begin
            bus.clu_out_fire_i = 1'b0;
        end
    end

    task automatic clear_mon();
        clr_req++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input logic [7:0] t, input logic [15:0] w, input logic [11:0] b);
        @(posedge clk);
        #1;
        cfg_tiles = t;
        cfg_win   = w;
        cfg_wbase = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, (done_cnt != 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"},  {31'd0, done}, 32'd0);
        check_eq({tag, "_tile"},  {24'd0, tile_idx}, 32'd0);
        check_eq({tag, "_re"},    {31'd0, bus.wmem_re}, 32'd0);
        check_eq({tag, "_addr"},  {20'd0, bus.wmem_addr}, 32'd0);
        check_eq({tag, "_wval"},  {31'd0, bus.weight_itf_valid_o}, 32'd0);
        check_eq({tag, "_cluv"},  {31'd0, bus.clu_valid_o}, 32'd0);
        check_eq({tag, "_srdy"},  {31'd0, bus.src_ready_o}, 32'd0);
        check_eq({tag, "_perf"},  perf, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst            = 1'b0;
        start           = 1'b0;
        cfg_tiles       = 8'd0;
        cfg_win         = 16'd0;
        cfg_wbase       = 12'd0;
        bus.src_valid_i = 1'b1;
        bus.clu_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("rst");
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("post_rst");

        // T1: one tile, four windows, bogus output fires during weight load.
        clear_mon();
        spurious_en = 1'b1;
        do_start(8'd1, 16'd4, 12'h010);
        wait_done(1000, "t1_done_seen");
        spurious_en = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("t1_reads",      re_cnt, 72);
        check_eq("t1_first_addr", {20'd0, first_addr}, 32'h010);
        check_eq("t1_last_addr",  {20'd0, last_addr}, 32'h057);
        check_eq("t1_addr_seq",   addr_err, 0);
        check_eq("t1_valid_cnt",  valid_cnt, 72);
        check_eq("t1_valid_lag",  valid_err, 0);
        check_eq("t1_wdata",      data_err, 0);
        check_eq("t1_accepts",    accepts, 4);
        check_eq("t1_fires_done", fires_at_done, 4);
        check_eq("t1_latency",    first_acc_cyc - start_cyc, 74);
        check_eq("t1_load_gate",  viol, 0);
        check_eq("t1_done_once",  done_cnt, 1);
        check_eq("t1_busy_after", {31'd0, busy}, 32'd0);

        // T2: three tiles with address wrap; a start while busy is ignored.
        clear_mon();
        do_start(8'd3, 16'd2, 12'hFF0);
        repeat (10) @(posedge clk);
        do_start(8'd1, 16'd1, 12'h000);
        wait_done(3000, "t2_done_seen");
        repeat (5) @(negedge clk);
        check_eq("t2_reads",      re_cnt, 216);
        check_eq("t2_first_addr", {20'd0, first_addr}, 32'hFF0);
        check_eq("t2_last_addr",  {20'd0, last_addr}, 32'h0C7);
        check_eq("t2_addr_seq",   addr_err, 0);
        check_eq("t2_wdata",      data_err, 0);
        check_eq("t2_bursts",     n_bursts, 3);
        check_eq("t2_tile0",      {24'd0, tile_seen[0]}, 32'd0);
        check_eq("t2_tile1",      {24'd0, tile_seen[1]}, 32'd1);
        check_eq("t2_tile2",      {24'd0, tile_seen[2]}, 32'd2);
        check_eq("t2_accepts",    accepts, 6);
        check_eq("t2_load_gate",  viol, 0);
        check_eq("t2_done_once",  done_cnt, 1);

        // T3: zero tiles -> done next cycle, no reads, never busy.
        clear_mon();
        @(posedge clk);
        #1;
        cfg_tiles = 8'd0;
        cfg_win   = 16'd3;
        cfg_wbase = 12'h123;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("t3_done_next",  {31'd0, done}, 32'd1);
        repeat (20) @(negedge clk);
        check_eq("t3_reads",      re_cnt, 0);
        check_eq("t3_busy_seen",  busy_seen, 0);
        check_eq("t3_done_once",  done_cnt, 1);

        // T4: zero windows, two tiles -> two loads, nothing admitted.
        clear_mon();
        do_start(8'd2, 16'd0, 12'h040);
        wait_done(1000, "t4_done_seen");
        repeat (5) @(negedge clk);
        check_eq("t4_reads",      re_cnt, 144);
        check_eq("t4_bursts",     n_bursts, 2);
        check_eq("t4_tile1",      {24'd0, tile_seen[1]}, 32'd1);
        check_eq("t4_accepts",    accepts, 0);
        check_eq("t4_done_once",  done_cnt, 1);

        // T5: cluster stalls for 5 STREAM cycles with a window offered.
        clear_mon();
        bus.clu_ready_i = 1'b0;
        do_start(8'd1, 16'd4, 12'h300);
        begin
            int k;
            k = 0;
            while (bus.clu_valid_o !== 1'b1 && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        check_eq("t5_stream_reached", {31'd0, bus.clu_valid_o}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check_eq("t5_frozen_accepts", accepts, 0);
`ifdef WSACC_SEQ_PERF_EN
        check_eq("t5_perf_stall", perf, 32'd5);
`else
        check_eq("t5_perf_stall", perf, 32'd0);
`endif
        bus.clu_ready_i = 1'b1;
        wait_done(1000, "t5_done_seen");
        repeat (5) @(negedge clk);
        check_eq("t5_accepts", accepts, 4);
`ifdef WSACC_SEQ_PERF_EN
        check_eq("t5_perf_hold", perf, 32'd5);
`else
        check_eq("t5_perf_hold", perf, 32'd0);
`endif

        // T6: reset during LOAD aborts; the next job starts cleanly.
        clear_mon();
        do_start(8'd2, 16'd2, 12'h100);
        repeat (20) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        check_idle_zero("t6_in_rst");
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        clear_mon();
        repeat (5) @(negedge clk);
        check_eq("t6_no_reads",  re_cnt, 0);
        check_eq("t6_no_done",   done_cnt, 0);
        do_start(8'd1, 16'd1, 12'h200);
        wait_done(1000, "t6_done_seen");
        repeat (3) @(negedge clk);
        check_eq("t6_first_addr", {20'd0, first_addr}, 32'h200);
        check_eq("t6_reads",      re_cnt, 72);
        check_eq("t6_accepts",    accepts, 1);
        check_eq("t6_done_once",  done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
